aes_key_schedule: RTL and testbench



---
 rtl/aes_pkg.sv | 62 ++++++
 rtl/aes_key_schedule_if.sv | 22 ++
 rtl/key_round_comb.sv | 30 +++
 rtl/aes_key_schedule.sv | 99 +++++++++
 tb/tb_aes_key_schedule.sv | 192 +++++++++++++++++++
 5 files changed

// File: rtl/aes_pkg.sv
// Shared AES constants, FSM state type, and the S-box/Rcon helpers.
// The S-box is also used by the cipher SubBytes stage.
package aes_pkg;

    localparam int unsigned NUM_ROUNDS = 10;
    localparam int unsigned KEY_W      = 128;
    localparam logic [3:0]  LAST_RND   = 4'(NUM_ROUNDS);

    typedef enum logic [0:0] {IDLE, EXPAND} state_t;

    function automatic logic [7:0] rcon(input logic [3:0] rnd);
        logic [7:0] r;
        unique case (rnd)
            4'd1:    r = 8'h01;
            4'd2:    r = 8'h02;
            4'd3:    r = 8'h04;
            4'd4:    r = 8'h08;
            4'd5:    r = 8'h10;
            4'd6:    r = 8'h20;
            4'd7:    r = 8'h40;
            4'd8:    r = 8'h80;
            4'd9:    r = 8'h1b;
            4'd10:   r = 8'h36;
            default: r = 8'h00;
        endcase
        return r;
    endfunction

    // GF(2^8) multiply modulo x^8+x^4+x^3+x+1
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Multiplicative inverse as x^254 (maps 0 to 0), then the affine transform
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] x2, x4, x8, x16, x32, x64, x128, inv;
        x2   = gf_mul(x, x);
        x4   = gf_mul(x2, x2);
        x8   = gf_mul(x4, x4);
        x16  = gf_mul(x8, x8);
        x32  = gf_mul(x16, x16);
        x64  = gf_mul(x32, x32);
        x128 = gf_mul(x64, x64);
        inv  = gf_mul(x2, x4);
        inv  = gf_mul(inv, x8);
        inv  = gf_mul(inv, x16);
        inv  = gf_mul(inv, x32);
        inv  = gf_mul(inv, x64);
        inv  = gf_mul(inv, x128);
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
             ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

endpackage

// File: rtl/aes_key_schedule_if.sv
// Control and read-port bundle between the key schedule and the cipher rounds.
interface aes_key_schedule_if;
    import aes_pkg::*;

    logic             start;
    logic [KEY_W-1:0] key_in;
    logic [3:0]       rd_addr;
    logic [KEY_W-1:0] rd_key;
    logic             busy;
    logic             done;
    logic             keys_valid;

    modport master (
        output start, key_in, rd_addr,
        input  rd_key, busy, done, keys_valid
    );

    modport slave (
        input  start, key_in, rd_addr,
        output rd_key, busy, done, keys_valid
    );
endinterface

// File: rtl/key_round_comb.sv
// One AES-128 key-expansion step: derives round key rnd from round key rnd-1.
module key_round_comb
    import aes_pkg::*;
(
    input  logic [KEY_W-1:0] prev_key,
    input  logic [3:0]       rnd,
    output logic [KEY_W-1:0] next_key
);

    logic [31:0] w0, w1, w2, w3;
    logic [31:0] rot, temp;
    logic [31:0] n0, n1, n2, n3;

    assign w0 = prev_key[127:96];
    assign w1 = prev_key[95:64];
    assign w2 = prev_key[63:32];
    assign w3 = prev_key[31:0];

    assign rot  = {w3[23:0], w3[31:24]};
    assign temp = {sbox(rot[31:24]), sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])}
                ^ {rcon(rnd), 24'h0};

    assign n0 = w0 ^ temp;
    assign n1 = w1 ^ n0;
    assign n2 = w2 ^ n1;
    assign n3 = w3 ^ n2;

    assign next_key = {n0, n1, n2, n3};

endmodule

// File: rtl/aes_key_schedule.sv
// Iterative AES-128 key schedule: one round key per clock into an 11-entry store,
// read back through a registered port.
module aes_key_schedule
    import aes_pkg::*;
(
    input logic              clk,
    input logic              reset,
    aes_key_schedule_if.slave bus
);

    state_t           state_q, state_d;
    logic [3:0]       rnd_q, rnd_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             valid_q, valid_d;
    logic [KEY_W-1:0] rd_key_q, rd_key_d;

    logic [KEY_W-1:0] store_q [NUM_ROUNDS+1];
    logic             store_we;
    logic [3:0]       wr_idx;
    logic [KEY_W-1:0] wr_data;
    logic [3:0]       prev_idx;
    logic [KEY_W-1:0] prev_key, next_key;

    assign prev_idx = (rnd_q == 4'd0) ? 4'd0 : rnd_q - 4'd1;
    assign prev_key = store_q[prev_idx];

    key_round_comb u_key_round (
        .prev_key (prev_key),
        .rnd      (rnd_q),
        .next_key (next_key)
    );

    always_comb begin
        state_d  = state_q;
        rnd_d    = rnd_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        valid_d  = valid_q;
        store_we = 1'b0;
        wr_idx   = rnd_q;
        wr_data  = next_key;
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d  = EXPAND;
                    rnd_d    = 4'd1;
                    busy_d   = 1'b1;
                    valid_d  = 1'b0;
                    store_we = 1'b1;
                    wr_idx   = 4'd0;
                    wr_data  = bus.key_in;
                end
            end
            EXPAND: begin
                store_we = 1'b1;
                rnd_d    = rnd_q + 4'd1;
                if (rnd_q == LAST_RND) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    valid_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Addresses past the last round key read as zero
    assign rd_key_d = (bus.rd_addr <= LAST_RND) ? store_q[bus.rd_addr] : '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            rnd_q    <= 4'd0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            valid_q  <= 1'b0;
            rd_key_q <= '0;
        end else begin
            state_q  <= state_d;
            rnd_q    <= rnd_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            valid_q  <= valid_d;
            rd_key_q <= rd_key_d;
        end
    end

    always_ff @(posedge clk) begin
        if (store_we) store_q[wr_idx] <= wr_data;
    end

    assign bus.rd_key     = rd_key_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.keys_valid = valid_q;

endmodule

// File: tb/tb_aes_key_schedule.sv
// Bench for aes_key_schedule: directed FIPS-197 vectors, reads checked via a scoreboard queue.
module tb_aes_key_schedule;

    localparam logic [127:0] KEY_A    = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] KEY_A_1  = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] KEY_A_2  = 128'hf2c295f27a96b9435935807a7359f67f;
    localparam logic [127:0] KEY_A_3  = 128'h3d80477d4716fe3e1e237e446d7a883b;
    localparam logic [127:0] KEY_A_10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] KEY_Z_1  = 128'h62636363626363636263636362636363;
    localparam logic [127:0] KEY_Z_2  = 128'h9b9898c9f9fbfbaa9b9898c9f9fbfbaa;
    localparam logic [127:0] KEY_Z_10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;
    localparam logic [127:0] KEY_C    = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] KEY_C_10 = 128'h13111d7fe3944a17f307a78b4d2b30c5;

    typedef struct {
        string        name;
        logic [127:0] val;
    } exp_t;

    logic clk;
    logic reset;
    logic rd_req;
    int   tests;
    int   failed;
    exp_t exp_q[$];

    aes_key_schedule_if bus ();

    aes_key_schedule dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every accepted read presents rd_key one edge later
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            if (rd_req) begin
                #1;
                if (exp_q.size() == 0) begin
                    check("sb_underflow", 128'd1, 128'd0);
                end else begin
                    e = exp_q.pop_front();
                    check(e.name, bus.rd_key, e.val);
                end
            end
        end
    end

    task automatic rd(input logic [3:0] addr, input logic [127:0] exp, input string name);
        exp_t e;
        @(negedge clk);
        bus.rd_addr = addr;
        rd_req      = 1'b1;
        e.name      = name;
        e.val       = exp;
        exp_q.push_back(e);
        @(negedge clk);
        rd_req = 1'b0;
    endtask

    // Accept key at T0, then count edges to done; optionally pulse start at edge T<inject>
    task automatic run_expand(input logic [127:0] key, input int inject, input string tag);
        int   n;
        logic got;
        @(negedge clk);
        bus.start  = 1'b1;
        bus.key_in = key;
        @(posedge clk);
        #1;
        check({tag, "_busy_at_accept"}, 128'(bus.busy), 128'd1);
        check({tag, "_valid_at_accept"}, 128'(bus.keys_valid), 128'd0);
        n   = 0;
        got = 1'b0;
        while (n < 20 && !got) begin
            @(negedge clk);
            bus.start = (n + 1 == inject);
            if (bus.start) bus.key_in = ~key;
            @(posedge clk);
            n++;
            #1;
            if (bus.done) got = 1'b1;
        end
        @(negedge clk);
        bus.start = 1'b0;
        check({tag, "_done_latency"}, 128'(n), 128'd10);
        check({tag, "_valid_after"}, 128'(bus.keys_valid), 128'd1);
        check({tag, "_idle_after"}, 128'(bus.busy), 128'd0);
        @(posedge clk);
        #1;
        check({tag, "_done_pulse"}, 128'(bus.done), 128'd0);
    endtask

    initial begin
        int wait_cyc;
        tests       = 0;
        failed      = 0;
        rd_req      = 1'b0;
        reset       = 1'b1;
        bus.start   = 1'b1;
        bus.key_in  = KEY_A;
        bus.rd_addr = 4'd0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 128'(bus.busy), 128'd0);
        check("rst_done", 128'(bus.done), 128'd0);
        check("rst_valid", 128'(bus.keys_valid), 128'd0);
        check("rst_rd_key", bus.rd_key, 128'd0);
        @(negedge clk);
        bus.start = 1'b0;
        reset     = 1'b0;

        run_expand(KEY_A, -1, "a");
        rd(4'd0, KEY_A, "a_k0");
        rd(4'd1, KEY_A_1, "a_k1");
        rd(4'd2, KEY_A_2, "a_k2");
        rd(4'd3, KEY_A_3, "a_k3");
        rd(4'd10, KEY_A_10, "a_k10");
        rd(4'd11, 128'd0, "a_addr11");
        rd(4'd15, 128'd0, "a_addr15");

        run_expand(128'd0, -1, "z");
        rd(4'd1, KEY_Z_1, "z_k1");
        rd(4'd2, KEY_Z_2, "z_k2");
        rd(4'd10, KEY_Z_10, "z_k10");
        rd(4'd0, 128'd0, "z_k0");

        // start at T3 while busy must be ignored
        run_expand(KEY_A, 3, "ign");
        rd(4'd1, KEY_A_1, "ign_k1");
        rd(4'd10, KEY_A_10, "ign_k10");

        // asynchronous reset between edges after T5
        @(negedge clk);
        bus.start   = 1'b1;
        bus.key_in  = KEY_C;
        bus.rd_addr = 4'd0;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (5) @(posedge clk);
        #3;
        check("mid_busy", 128'(bus.busy), 128'd1);
        check("mid_rd_key", bus.rd_key, KEY_C);
        reset = 1'b1;
        #1;
        check("async_busy", 128'(bus.busy), 128'd0);
        check("async_valid", 128'(bus.keys_valid), 128'd0);
        check("async_done", 128'(bus.done), 128'd0);
        check("async_rd_key", bus.rd_key, 128'd0);
        @(negedge clk);
        reset = 1'b0;

        run_expand(KEY_C, -1, "c");
        rd(4'd0, KEY_C, "c_k0");
        rd(4'd10, KEY_C_10, "c_k10");

        // restart over a complete schedule with a different key
        run_expand(KEY_A, -1, "re");
        rd(4'd10, KEY_A_10, "re_k10");

        wait_cyc = 0;
        while (exp_q.size() != 0 && wait_cyc < 20) begin
            @(posedge clk);
            wait_cyc++;
        end
        check("sb_drain", 128'(exp_q.size()), 128'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
